victim_select: RTL

//  Second-chance (clock-hand) replacement selector; write-side partner of the classification-bit tracker.

---
 rtl/victim_select_if.sv | 31 +++
 rtl/victim_select.sv | 111 +++++++++++
 2 files changed

// File: rtl/victim_select_if.sv
// Allocation bus between the fill/allocate requester, the classification-bit
// tracker and the second-chance victim selector.
interface victim_select_if #(
    parameter int N_ENTRIES = 32,
    parameter int ADDR_W    = 5
);
    // Requester / tracker side
    logic                 alloc_req;
    logic [N_ENTRIES-1:0] class_bits;
    logic [N_ENTRIES-1:0] valid_bits;

    // Selector side
    logic                 alloc_busy;
    logic                 alloc_ack;
    logic [ADDR_W-1:0]    victim_addr;
    logic                 we;
    logic [ADDR_W-1:0]    write_addr;
    logic [ADDR_W-1:0]    hand;

    // Requester plus tracker: drives the request and the per-entry state bits
    modport master (
        output alloc_req, class_bits, valid_bits,
        input  alloc_busy, alloc_ack, victim_addr, we, write_addr, hand
    );

    // Victim selector
    modport slave (
        input  alloc_req, class_bits, valid_bits,
        output alloc_busy, alloc_ack, victim_addr, we, write_addr, hand
    );
endinterface

// File: rtl/victim_select.sv
// Second-chance (clock-hand) victim selector. On an allocate request it walks
// the entries from the current hand, one per cycle, and picks the first free
// or not-reused entry. If a full sweep finds every entry valid and reused, the
// entry at the starting hand is taken. The grant issues a one-cycle write
// strobe so the tracker can fill the entry and clear its classification bit.
module victim_select #(
    parameter int N_ENTRIES = 32,
    parameter int ADDR_W    = 5
) (
    input  logic           clk,
    input  logic           rst,
    victim_select_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GRANT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(N_ENTRIES - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] hand_q;
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] victim_q;
    logic [ADDR_W-1:0] write_addr_q;
    logic              busy_q;
    logic              ack_q;
    logic              we_q;

    // Entry under the scan pointer is replaceable if free or not reused.
    // The bits are sampled live: an entry already passed is never revisited.
    logic              idx_replaceable;
    assign idx_replaceable = !bus.valid_bits[idx_q] || !bus.class_bits[idx_q];

    // Scan FSM: all outputs come straight from registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state        <= IDLE;
            hand_q       <= '0;
            start_q      <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            victim_q     <= '0;
            write_addr_q <= '0;
            busy_q       <= 1'b0;
            ack_q        <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.alloc_req) begin
                        start_q <= hand_q;
                        idx_q   <= hand_q;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state   <= SCAN;
                    end
                end

                SCAN: begin
                    if (idx_replaceable) begin
                        victim_q     <= idx_q;
                        write_addr_q <= idx_q;
                        ack_q        <= 1'b1;
                        we_q         <= 1'b1;
                        state        <= GRANT;
                    end else if (cnt_q == LAST_CNT) begin
                        // Every entry valid and reused: evict where we started
                        victim_q     <= start_q;
                        write_addr_q <= start_q;
                        ack_q        <= 1'b1;
                        we_q         <= 1'b1;
                        state        <= GRANT;
                    end else begin
                        // Index wraps N-1 -> 0 through natural overflow
                        idx_q <= idx_q + ONE;
                        cnt_q <= cnt_q + ONE;
                    end
                end

                GRANT: begin
                    // Requests seen here are dropped; next accept is in IDLE
                    ack_q  <= 1'b0;
                    we_q   <= 1'b0;
                    busy_q <= 1'b0;
                    hand_q <= victim_q + ONE;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.alloc_busy  = busy_q;
    assign bus.alloc_ack   = ack_q;
    assign bus.victim_addr = victim_q;
    assign bus.we          = we_q;
    assign bus.write_addr  = write_addr_q;
    assign bus.hand        = hand_q;

endmodule
